// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between an instruction-fetch requester (IF) and a
// data requester (DM). A small FSM (IDLE / IF_ACC / DM_ACC) grants one
// requester at a time, latches its request fields for the whole access and
// waits for mem_ack. An access with no ack for TIMEOUT cycles is aborted.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   if_req, if_addr           fetch request / byte address
//   if_rdata, if_ready        fetched word (registered) / completion pulse
//   dm_req, dm_we, dm_addr    data request, store enable, byte address
//   dm_wdata, dm_func3        store data, access size/sign (passed through)
//   dm_rdata, dm_ready        load data (registered) / completion pulse
//   mem_en, mem_we            memory strobe and write enable
//   mem_addr, mem_wdata,
//   mem_func3                 latched request fields
//   mem_rdata, mem_ack        memory read data / completion (same cycle)
//   err                       one-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_func3,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IF_ACC = 2'd1;
  localparam logic [1:0] DM_ACC = 2'd2;

  // Last ACC cycle that may still wait: the counter holds the number of
  // ACC cycles already spent without ack.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] FUNC3_WORD = 3'b010;

  logic [1:0]        state_q, state_d;
  logic              last_dm_q, last_dm_d;   // 1: DM was granted last
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        func3_q, func3_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              err_q, err_d;

  logic if_elig, dm_elig, grant_if, grant_dm;

  // A requester in its ready cycle still holds req; it must not be
  // re-granted for the access that just completed.
  assign if_elig  = if_req & ~if_ready_q;
  assign dm_elig  = dm_req & ~dm_ready_q;
  assign grant_if = if_elig & (~dm_elig | last_dm_q);
  assign grant_dm = dm_elig & ~grant_if;

  always_comb begin
    state_d    = state_q;
    last_dm_d  = last_dm_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    func3_d    = func3_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d   = IF_ACC;
          last_dm_d = 1'b0;
          cnt_d     = '0;
          addr_d    = if_addr;
          wdata_d   = '0;
          we_d      = 1'b0;
          func3_d   = FUNC3_WORD;
        end else if (grant_dm) begin
          state_d   = DM_ACC;
          last_dm_d = 1'b1;
          cnt_d     = '0;
          addr_d    = dm_addr;
          wdata_d   = dm_wdata;
          we_d      = dm_we;
          func3_d   = dm_func3;
        end
      end

      IF_ACC, DM_ACC: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (state_q == IF_ACC) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            // Stores leave the load data register untouched.
            if (!we_q) dm_rdata_d = mem_rdata;
            dm_ready_d = 1'b1;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          if (state_q == IF_ACC) begin
            if_rdata_d = '0;
            if_ready_d = 1'b1;
          end else begin
            dm_rdata_d = '0;
            dm_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_dm_q  <= 1'b1;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      func3_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dm_q  <= last_dm_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      func3_q    <= func3_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      err_q      <= err_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them
  // without waiting for a clock edge.
  assign mem_en    = (state_q != IDLE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_func3 = func3_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [11:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [2:0]  dm_func3 = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_func3(dm_func3), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [11:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_func3;
    logic        ack;
    logic [31:0] mrd;
    logic        e_en;
    logic        e_we;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;
    logic [2:0]  e_f3;
    logic        e_ifr;
    logic        e_dmr;
    logic        e_err;
    logic [31:0] e_ifd;
    logic [31:0] e_dmd;
  } vec_t;

  localparam int NV = 20;
  vec_t vt[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int n_en, n_err;
    bit got;

    // Each row: inputs driven for the cycle, outputs expected in that cycle.
    //         rst if  ifaddr  dm we dmaddr  wdata         f3    ack rdata
    //         en we addr    wdata         f3    ifr dmr err ifd           dmd
    vt[0]  = '{1,0,12'h000,0,0,12'h000,32'h0,3'b000,0,32'h0,
               0,0,12'h000,32'h0,3'b000,0,0,0,32'h0,32'h0};
    vt[1]  = '{0,1,12'h004,0,0,12'h000,32'h0,3'b000,0,32'h0,
               0,0,12'h000,32'h0,3'b000,0,0,0,32'h0,32'h0};
    vt[2]  = '{0,1,12'h004,0,0,12'h000,32'h0,3'b000,0,32'h0,
               1,0,12'h004,32'h0,3'b010,0,0,0,32'h0,32'h0};
    vt[3]  = '{0,1,12'h004,0,0,12'h000,32'h0,3'b000,1,32'h00500093,
               1,0,12'h004,32'h0,3'b010,0,0,0,32'h0,32'h0};
    vt[4]  = '{0,0,12'h004,0,0,12'h000,32'h0,3'b000,0,32'h0,
               0,0,12'h004,32'h0,3'b010,1,0,0,32'h00500093,32'h0};
    vt[5]  = '{0,0,12'h004,0,0,12'h000,32'h0,3'b000,0,32'h0,
               0,0,12'h004,32'h0,3'b010,0,0,0,32'h00500093,32'h0};
    vt[6]  = '{1,0,12'h000,0,0,12'h000,32'h0,3'b000,0,32'h0,
               0,0,12'h000,32'h0,3'b000,0,0,0,32'h0,32'h0};
    vt[7]  = '{0,1,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,0,32'h0,
               0,0,12'h000,32'h0,3'b000,0,0,0,32'h0,32'h0};
    vt[8]  = '{0,1,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,1,32'hAAAA0001,
               1,0,12'h008,32'h0,3'b010,0,0,0,32'h0,32'h0};
    vt[9]  = '{0,1,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,0,32'h0,
               0,0,12'h008,32'h0,3'b010,1,0,0,32'hAAAA0001,32'h0};
    vt[10] = '{0,1,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,1,32'h55555555,
               1,1,12'h100,32'hDEADBEEF,3'b001,0,0,0,32'hAAAA0001,32'h0};
    vt[11] = '{0,1,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,0,32'h0,
               0,0,12'h100,32'hDEADBEEF,3'b001,0,1,0,32'hAAAA0001,32'h0};
    vt[12] = '{0,1,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,1,32'hAAAA0002,
               1,0,12'h008,32'h0,3'b010,0,0,0,32'hAAAA0001,32'h0};
    vt[13] = '{0,0,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,0,32'h0,
               0,0,12'h008,32'h0,3'b010,1,0,0,32'hAAAA0002,32'h0};
    vt[14] = '{0,0,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,1,32'h0,
               1,1,12'h100,32'hDEADBEEF,3'b001,0,0,0,32'hAAAA0002,32'h0};
    vt[15] = '{0,0,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,0,32'h0,
               0,0,12'h100,32'hDEADBEEF,3'b001,0,1,0,32'hAAAA0002,32'h0};
    vt[16] = '{0,0,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,0,32'h0,
               0,0,12'h100,32'hDEADBEEF,3'b001,0,0,0,32'hAAAA0002,32'h0};
    vt[17] = '{0,0,12'h008,1,1,12'h100,32'hDEADBEEF,3'b001,1,32'h0,
               1,1,12'h100,32'hDEADBEEF,3'b001,0,0,0,32'hAAAA0002,32'h0};
    vt[18] = '{0,0,12'h008,0,1,12'h100,32'hDEADBEEF,3'b001,0,32'h0,
               0,0,12'h100,32'hDEADBEEF,3'b001,0,1,0,32'hAAAA0002,32'h0};
    vt[19] = '{0,0,12'h008,0,1,12'h100,32'hDEADBEEF,3'b001,0,32'h0,
               0,0,12'h100,32'hDEADBEEF,3'b001,0,0,0,32'hAAAA0002,32'h0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst      = vt[i].rst;
      if_req   = vt[i].if_req;
      if_addr  = vt[i].if_addr;
      dm_req   = vt[i].dm_req;
      dm_we    = vt[i].dm_we;
      dm_addr  = vt[i].dm_addr;
      dm_wdata = vt[i].dm_wdata;
      dm_func3 = vt[i].dm_func3;
      mem_ack  = vt[i].ack;
      mem_rdata = vt[i].mrd;
      #1;
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vt[i].e_en));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d mem_func3", i), 32'(mem_func3), 32'(vt[i].e_f3));
      chk($sformatf("v%0d if_ready", i), 32'(if_ready), 32'(vt[i].e_ifr));
      chk($sformatf("v%0d dm_ready", i), 32'(dm_ready), 32'(vt[i].e_dmr));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("v%0d if_rdata", i), if_rdata, vt[i].e_ifd);
      chk($sformatf("v%0d dm_rdata", i), dm_rdata, vt[i].e_dmd);
    end

    // Load completes, then a load that never gets an ack times out.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h040; dm_func3 = 3'b000;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("load mem_en", 32'(mem_en), 32'd1);
    chk("load mem_addr", 32'(mem_addr), 32'h040);
    @(negedge clk);
    mem_ack = 1'b0; dm_req = 1'b0;
    #1;
    chk("load dm_ready", 32'(dm_ready), 32'd1);
    chk("load dm_rdata", dm_rdata, 32'hCAFEF00D);
    @(negedge clk);
    dm_req = 1'b1;
    n_en = 0; n_err = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      if (dm_ready) got = 1'b1;
      else begin
        if (mem_en) n_en++;
        if (err) n_err++;
      end
    end
    dm_req = 1'b0;
    chk("tmo reached", 32'(got), 32'd1);
    chk("tmo acc cycles", n_en, 15);
    chk("tmo early err", n_err, 0);
    chk("tmo err", 32'(err), 32'd1);
    chk("tmo dm_rdata", dm_rdata, 32'h0);
    chk("tmo mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    #1;
    chk("tmo err pulse", 32'(err), 32'd0);
    chk("tmo ready pulse", 32'(dm_ready), 32'd0);
    chk("tmo idle", 32'(mem_en), 32'd0);

    // Asynchronous reset in the middle of a data access.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h080;
    @(negedge clk);
    #1;
    chk("arst acc mem_en", 32'(mem_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst mem_en now", 32'(mem_en), 32'd0);
    chk("arst mem_addr now", 32'(mem_addr), 32'h0);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("arst c%0d dm_ready", i), 32'(dm_ready), 32'd0);
      chk($sformatf("arst c%0d mem_en", i), 32'(mem_en), 32'd0);
      chk($sformatf("arst c%0d dm_rdata", i), dm_rdata, 32'h0);
    end
    mem_ack = 1'b0;

    // Fetch request pulsed for a single cycle; ack on the 4th ACC cycle.
    @(negedge clk);
    if_req = 1'b1; if_addr = 12'h0C0;
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("drop mem_en", 32'(mem_en), 32'd1);
    chk("drop mem_addr", 32'(mem_addr), 32'h0C0);
    n_en = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      if (mem_en) n_en++;
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    #1;
    if (mem_en) n_en++;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("drop acc cycles", n_en, 4);
    chk("drop if_ready", 32'(if_ready), 32'd1);
    chk("drop if_rdata", if_rdata, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("drop c%0d no regrant", i), 32'(mem_en), 32'd0);
      chk($sformatf("drop c%0d if_ready", i), 32'(if_ready), 32'd0);
      chk($sformatf("drop c%0d if_rdata", i), if_rdata, 32'h12345678);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
